led_matrix_scanner: RTL and testbench

Consumes the 16×16 red and green pixel arrays produced by the game display logic and drives the physical LED matrix. Each row's 32 colour bits are shifted serially into external column shift/latch registers, latched, and the row is then lit for a fixed dwell before the next row is processed. Sits between the game/display layer (`RedPixels`/`GrnPixels` producer) and the board pins.

---
 rtl/led_matrix_scanner_pkg.sv | 39 +++
 rtl/led_matrix_scanner_if.sv | 53 +++++
 rtl/led_matrix_scanner_shift_out.sv | 97 +++++++++
 rtl/led_matrix_scanner.sv | 142 ++++++++++++++
 tb/tb_led_matrix_scanner.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/led_matrix_scanner_pkg.sv
// ---------------------------------------------------------------------------
// led_scan_pkg
// Shared definitions for the LED matrix scanner: matrix geometry, the scan
// FSM state type and small helpers used to size counters and build the
// one-hot row drive.
// No ports (package).
// ---------------------------------------------------------------------------
package led_scan_pkg;

  localparam int ROWS         = 16;
  localparam int COLS         = 16;
  localparam int BITS_PER_ROW = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    LATCH   = 3'd3,
    DISPLAY = 3'd4
  } scan_state_t;

  // Width needed for a counter that runs 0..n-1; never narrower than 1 bit so
  // that degenerate parameter values (n == 1) still give a legal vector.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // One-hot active-high drive for the given row.
  function automatic logic [ROWS-1:0] row_onehot(input logic [3:0] row);
    logic [ROWS-1:0] one;
    one = {{(ROWS-1){1'b0}}, 1'b1};
    return one << row;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// ---------------------------------------------------------------------------
// led_matrix_scanner_if
// Bundles the display-layer inputs (enable, pixel arrays) and the board pin
// outputs of the scanner.
//   master : display layer / board side (drives enable and pixels)
//   slave  : the scanner itself (drives serial, latch and row pins)
// Signals:
//   enable                 scan enable
//   RedPixels, GrnPixels   [row][col] pixel arrays
//   ser_data, ser_clk      serial column data and shift clock
//   ser_latch              column latch pulse
//   row_sel                one-hot active-high row drive
//   oe_n                   column output enable, active-low
//   frame_start            pulse when row 0 load begins
// ---------------------------------------------------------------------------
interface led_matrix_scanner_if;
  import led_scan_pkg::*;

  logic                       enable;
  logic [ROWS-1:0][COLS-1:0]  RedPixels;
  logic [ROWS-1:0][COLS-1:0]  GrnPixels;
  logic                       ser_data;
  logic                       ser_clk;
  logic                       ser_latch;
  logic [ROWS-1:0]            row_sel;
  logic                       oe_n;
  logic                       frame_start;

  modport master (
    output enable,
    output RedPixels,
    output GrnPixels,
    input  ser_data,
    input  ser_clk,
    input  ser_latch,
    input  row_sel,
    input  oe_n,
    input  frame_start
  );

  modport slave (
    input  enable,
    input  RedPixels,
    input  GrnPixels,
    output ser_data,
    output ser_clk,
    output ser_latch,
    output row_sel,
    output oe_n,
    output frame_start
  );

endinterface

// File: rtl/led_matrix_scanner_shift_out.sv
// ---------------------------------------------------------------------------
// led_shift_out
// Serialises one 32-bit row word MSB first. Each bit occupies 2*CLK_DIV
// clocks: ser_clk low for the first CLK_DIV clocks, high for the next
// CLK_DIV, with ser_data stable across the whole bit period.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   load         1-cycle request; captures data_in and starts shifting
//   data_in      row word, bit 31 goes out first
//   ser_data     serial data (registered)
//   ser_clk      shift clock (registered), 0 when idle
//   done         high during the final clock of the final bit
// ---------------------------------------------------------------------------
module led_shift_out
  import led_scan_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BITS_PER_ROW-1:0] data_in,
  output logic                    ser_data,
  output logic                    ser_clk,
  output logic                    done
);

  localparam int PW = cnt_width(2 * CLK_DIV);
  localparam logic [PW-1:0] PHASE_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PHASE_HIGH = PW'(CLK_DIV);
  localparam logic [4:0]    BIT_LAST   = 5'(BITS_PER_ROW - 1);

  logic [BITS_PER_ROW-1:0] shreg_q, shreg_d;
  logic [4:0]              bit_q, bit_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic                    active_q, active_d;
  logic                    ser_clk_q, ser_clk_d;
  logic                    ser_data_q, ser_data_d;
  logic                    done_s;

  // Next-state for the shifter; ser_clk/ser_data are derived from the next
  // phase/register so that the pins are flop outputs aligned with the state.
  always_comb begin
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    active_d = active_q;
    done_s   = 1'b0;
    if (load) begin
      shreg_d  = data_in;
      bit_d    = 5'd0;
      phase_d  = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (phase_q == PHASE_LAST) begin
        phase_d = '0;
        if (bit_q == BIT_LAST) begin
          active_d = 1'b0;
          done_s   = 1'b1;
        end else begin
          bit_d   = bit_q + 5'd1;
          shreg_d = {shreg_q[BITS_PER_ROW-2:0], 1'b0};
        end
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end else begin
      done_s = 1'b0;
    end
    ser_clk_d  = active_d && (phase_d >= PHASE_HIGH);
    ser_data_d = active_d ? shreg_d[BITS_PER_ROW-1] : 1'b0;
  end

  // Shifter state registers; reset discards any partial row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q    <= '0;
      bit_q      <= 5'd0;
      phase_q    <= '0;
      active_q   <= 1'b0;
      ser_clk_q  <= 1'b0;
      ser_data_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      active_q   <= active_d;
      ser_clk_q  <= ser_clk_d;
      ser_data_q <= ser_data_d;
    end
  end

  assign ser_clk  = ser_clk_q;
  assign ser_data = ser_data_q;
  assign done     = done_s;

endmodule

// File: rtl/led_matrix_scanner.sv
// ---------------------------------------------------------------------------
// led_matrix_scanner
// Scans a 16x16 red/green LED matrix one row at a time: snapshot the row's
// 32 colour bits, shift them out serially, latch them into the column
// registers, then light the row for DWELL clocks. Rows are blanked in every
// phase except the dwell so the column data never changes while lit.
// Parameters:
//   CLK_DIV   system clocks per ser_clk half-period (>= 1)
//   DWELL     clocks each row is lit (>= 1)
// Ports:
//   clk       system clock
//   RST       asynchronous active-high reset
//   bus       led_matrix_scanner_if.slave (enable, pixels in; pins out)
// ---------------------------------------------------------------------------
module led_matrix_scanner
  import led_scan_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DWELL   = 256
) (
  input  logic                  clk,
  input  logic                  RST,
  led_matrix_scanner_if.slave   bus
);

  localparam int DW = cnt_width(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  scan_state_t      state_q, state_d;
  logic [3:0]       row_q, row_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [ROWS-1:0]  row_sel_q, row_sel_d;
  logic             oe_n_q, oe_n_d;
  logic             ser_latch_q, ser_latch_d;
  logic             frame_start_q, frame_start_d;

  logic                    load_s;
  logic [BITS_PER_ROW-1:0] row_word_s;
  logic                    shift_done_s;

  // Red word occupies the upper half so it leaves the shifter first.
  assign row_word_s = {bus.RedPixels[row_q], bus.GrnPixels[row_q]};

  led_shift_out #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk      (clk),
    .rst      (RST),
    .load     (load_s),
    .data_in  (row_word_s),
    .ser_data (bus.ser_data),
    .ser_clk  (bus.ser_clk),
    .done     (shift_done_s)
  );

  // Scan FSM next-state logic. Pin values are computed for the state being
  // entered, so the registered pins line up with the registered state.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    dwell_d       = dwell_q;
    load_s        = 1'b0;
    row_sel_d     = '0;
    oe_n_d        = 1'b1;
    ser_latch_d   = 1'b0;
    frame_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Row counter is kept, so scanning resumes where it stopped.
        if (bus.enable) begin
          state_d       = LOAD;
          frame_start_d = (row_q == 4'd0);
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        load_s  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (shift_done_s) begin
          state_d     = LATCH;
          ser_latch_d = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      LATCH: begin
        state_d   = DISPLAY;
        dwell_d   = '0;
        row_sel_d = row_onehot(row_q);
        oe_n_d    = 1'b0;
      end
      DISPLAY: begin
        if (dwell_q == DWELL_LAST) begin
          row_d = (row_q == 4'd15) ? 4'd0 : (row_q + 4'd1);
          if (bus.enable) begin
            state_d       = LOAD;
            frame_start_d = (row_d == 4'd0);
          end else begin
            state_d = IDLE;
          end
        end else begin
          dwell_d   = dwell_q + DW'(1);
          row_sel_d = row_onehot(row_q);
          oe_n_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scan FSM state, counters and registered pin outputs.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      row_q         <= 4'd0;
      dwell_q       <= '0;
      row_sel_q     <= '0;
      oe_n_q        <= 1'b1;
      ser_latch_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      dwell_q       <= dwell_d;
      row_sel_q     <= row_sel_d;
      oe_n_q        <= oe_n_d;
      ser_latch_q   <= ser_latch_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.row_sel     = row_sel_q;
  assign bus.oe_n        = oe_n_q;
  assign bus.ser_latch   = ser_latch_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// ---------------------------------------------------------------------------
// tb_led_matrix_scanner
// Two scanners: u0 with default timing (CLK_DIV=2, DWELL=256) and u1 with
// CLK_DIV=1, DWELL=1. Pixel arrays are random per row; the expected serial
// word for a row is taken from the bench's own pixel arrays as they stand
// when the row is loaded, and the expected periods come from the row period
// formula 1 + 64*CLK_DIV + 1 + DWELL.
// ---------------------------------------------------------------------------
module tb_led_matrix_scanner;

  logic clk;
  logic rst;
  logic en [2];
  logic [15:0] red_m [2][16];
  logic [15:0] grn_m [2][16];

  int checks;
  int failures;
  int cyc;
  int inv_err;
  int last_latch [2];
  int fs_times [$];

  led_matrix_scanner_if bus0 ();
  led_matrix_scanner_if bus1 ();

  assign bus0.enable = en[0];
  assign bus1.enable = en[1];

  always_comb begin
    for (int r = 0; r < 16; r++) begin
      bus0.RedPixels[r] = red_m[0][r];
      bus0.GrnPixels[r] = grn_m[0][r];
      bus1.RedPixels[r] = red_m[1][r];
      bus1.GrnPixels[r] = grn_m[1][r];
    end
  end

  led_matrix_scanner #(.CLK_DIV(2), .DWELL(256)) u0 (.clk(clk), .RST(rst), .bus(bus0));
  led_matrix_scanner #(.CLK_DIV(1), .DWELL(1))   u1 (.clk(clk), .RST(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Invariants on both scanners and frame_start timestamps for u0.
  always @(negedge clk) begin
    if (!rst) begin
      if ((bus0.row_sel & (bus0.row_sel - 16'd1)) != 16'd0) inv_err <= inv_err + 1;
      if ((bus1.row_sel & (bus1.row_sel - 16'd1)) != 16'd0) inv_err <= inv_err + 1;
      if (bus0.oe_n && bus0.row_sel != 16'd0) inv_err <= inv_err + 1;
      if (bus1.oe_n && bus1.row_sel != 16'd0) inv_err <= inv_err + 1;
      if (bus0.ser_latch && bus0.ser_clk) inv_err <= inv_err + 1;
      if (bus1.ser_latch && bus1.ser_clk) inv_err <= inv_err + 1;
      if (bus0.frame_start) fs_times.push_back(cyc);
    end
  end

  function automatic logic get_ser_clk(input int idx);
    if (idx == 0) return bus0.ser_clk; else return bus1.ser_clk;
  endfunction
  function automatic logic get_ser_data(input int idx);
    if (idx == 0) return bus0.ser_data; else return bus1.ser_data;
  endfunction
  function automatic logic get_latch(input int idx);
    if (idx == 0) return bus0.ser_latch; else return bus1.ser_latch;
  endfunction
  function automatic logic get_oe_n(input int idx);
    if (idx == 0) return bus0.oe_n; else return bus1.oe_n;
  endfunction
  function automatic logic [15:0] get_row_sel(input int idx);
    if (idx == 0) return bus0.row_sel; else return bus1.row_sel;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Follows one row of scanner idx from LOAD through DISPLAY.
  // action 1: clear red row 3 after the first bit; action 2: drop enable.
  task automatic scan_row(input int idx, input int row, input int action,
                          input bit chk_period, output int first_rise);
    logic [31:0] exp_w;
    logic [31:0] got;
    logic        prev;
    int          nbits, n, dw, high_run, max_high, cd, period, dwell;
    bit          seen;
    cd     = (idx == 0) ? 2 : 1;
    dwell  = (idx == 0) ? 256 : 1;
    period = 1 + 64 * cd + 1 + dwell;
    exp_w  = {red_m[idx][row], grn_m[idx][row]};
    got = '0; prev = 1'b0; nbits = 0; n = 0; seen = 1'b0;
    high_run = 0; max_high = 0; first_rise = -1;
    while (!seen && n < 4000) begin
      @(negedge clk);
      n++;
      if (get_ser_clk(idx)) begin
        high_run++;
        if (high_run > max_high) max_high = high_run;
      end else begin
        high_run = 0;
      end
      if (get_ser_clk(idx) && !prev) begin
        got = {got[30:0], get_ser_data(idx)};
        nbits++;
        if (nbits == 1) begin
          first_rise = n;
          if (action == 1) red_m[idx][3] = 16'h0000;
          if (action == 2) en[idx] = 1'b0;
        end
      end
      prev = get_ser_clk(idx);
      if (get_latch(idx)) seen = 1'b1;
    end
    chk($sformatf("u%0d_row%0d_latch_seen", idx, row), {31'd0, seen}, 32'd1);
    chk($sformatf("u%0d_row%0d_word", idx, row), got, exp_w);
    chk($sformatf("u%0d_row%0d_nbits", idx, row), nbits, 32'd32);
    chk($sformatf("u%0d_row%0d_clk_high", idx, row), max_high, cd);
    if (chk_period) chk($sformatf("u%0d_row%0d_period", idx, row), cyc - last_latch[idx], period);
    last_latch[idx] = cyc;
    dw = 0; n = 0;
    @(negedge clk);
    while (!get_oe_n(idx) && get_row_sel(idx) == (16'h0001 << row) && n < 1000) begin
      dw++; n++;
      @(negedge clk);
    end
    chk($sformatf("u%0d_row%0d_dwell", idx, row), dw, dwell);
  endtask

  initial begin
    int fr;
    int bad;
    int rises;
    int n;
    bit seen;
    logic prev;
    checks = 0; failures = 0; cyc = 0; inv_err = 0;
    last_latch[0] = 0; last_latch[1] = 0;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 16; r++) begin
        red_m[d][r] = 16'($urandom);
        grn_m[d][r] = 16'($urandom);
      end
    end
    red_m[0][0] = 16'hA5C3;
    grn_m[0][0] = 16'h0F01;
    red_m[0][3] = 16'hFFFF;

    // Reset held with enable high on u0.
    rst = 1'b1; en[0] = 1'b1; en[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_oe_n", {31'd0, bus0.oe_n}, 32'd1);
    chk("rst_row_sel", {16'd0, bus0.row_sel}, 32'd0);
    chk("rst_ser_data", {31'd0, bus0.ser_data}, 32'd0);
    chk("rst_ser_clk", {31'd0, bus0.ser_clk}, 32'd0);
    chk("rst_ser_latch", {31'd0, bus0.ser_latch}, 32'd0);
    chk("rst_frame_start", {31'd0, bus0.frame_start}, 32'd0);
    chk("rst_u1_oe_n", {31'd0, bus1.oe_n}, 32'd1);
    rst = 1'b0;

    // Frame 1: rows 0..15; row 3 red cleared mid-shift (snapshot must hold).
    for (int r = 0; r < 16; r++) begin
      scan_row(0, r, (r == 3) ? 1 : 0, r != 0, fr);
    end
    // Frame 2: rows 0..5, enable dropped during row 5 shift.
    for (int r = 0; r < 6; r++) begin
      scan_row(0, r, (r == 5) ? 2 : 0, 1'b1, fr);
    end
    chk("frame_start_count", fs_times.size(), 32'd2);
    if (fs_times.size() >= 2) chk("frame_period", fs_times[1] - fs_times[0], 32'd6176);

    // Idle after enable drop: blanked and no shifting.
    bad = 0; rises = 0; prev = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (!bus0.oe_n || bus0.row_sel != 16'd0) bad++;
      if (bus0.ser_clk && !prev) rises++;
      prev = bus0.ser_clk;
    end
    chk("idle_blanked", bad, 32'd0);
    chk("idle_no_ser_clk", rises, 32'd0);

    // Resume at row 6; first ser_clk rise seen 2 + CLK_DIV cycles after enable.
    en[0] = 1'b1;
    scan_row(0, 6, 0, 1'b0, fr);
    chk("resume_first_rise", fr, 32'd4);
    chk("resume_no_frame_start", fs_times.size(), 32'd2);

    // Parameter sweep scanner: row period 67, 1-cycle ser_clk half-period.
    en[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      scan_row(1, k % 16, 0, k != 0, fr);
      if (k == 0) chk("u1_first_rise", fr, 32'd3);
    end

    chk("invariants", inv_err, 32'd0);

    // Asynchronous reset while u0 is entering DISPLAY.
    seen = 1'b0; n = 0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      if (bus0.ser_latch) seen = 1'b1;
    end
    chk("async_rst_latch_seen", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_oe_n", {31'd0, bus0.oe_n}, 32'd1);
    chk("async_rst_row_sel", {16'd0, bus0.row_sel}, 32'd0);
    chk("async_rst_ser_clk", {31'd0, bus0.ser_clk}, 32'd0);
    chk("async_rst_ser_data", {31'd0, bus0.ser_data}, 32'd0);
    chk("async_rst_u1_oe_n", {31'd0, bus1.oe_n}, 32'd1);
    chk("async_rst_u1_ser_clk", {31'd0, bus1.ser_clk}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Row counter cleared: the restart is a row-0 load.
    @(negedge clk);
    chk("restart_frame_start", {31'd0, bus0.frame_start}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
